// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   FWD_RF        : forward-select value meaning "use the register file".
//   REG_BITS_MAX  : widest register number a slot record can hold.
//   clog2()       : ceiling log2 for select-width sizing.
//   slot_t        : one tracked post-decode slot {valid, wr_en, rd, is_load}.
//   params_legal(): elaboration-time parameter range check.
package pipe_ctrl_pkg;

  localparam int FWD_RF       = 0;
  localparam int REG_BITS_MAX = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // rd is stored zero-extended to REG_BITS_MAX so one record type serves any REG_BITS.
  typedef struct packed {
    logic                    valid;
    logic                    wr_en;
    logic [REG_BITS_MAX-1:0] rd;
    logic                    is_load;
  } slot_t;

  function automatic bit params_legal(input int reg_bits, input int stages,
                                      input int load_ready, input int cnt_w);
    return (reg_bits >= 1) && (reg_bits <= REG_BITS_MAX) &&
           (stages >= 2) && (stages <= 8) &&
           (load_ready >= 1) && (load_ready <= stages - 1) &&
           (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage to hazard controller bus.
//   master : pipeline side; drives the decoded ID instruction, flush, stall_ext,
//            receives stall_id, fwd_a/fwd_b, slot_valid, stall_cycles.
//   slave  : hazard_forward_ctrl side.
interface hazard_forward_ctrl_if #(
  parameter int REG_BITS = 5,
  parameter int STAGES   = 3,
  parameter int CNT_W    = 16
);
  import pipe_ctrl_pkg::*;
  localparam int FWD_W = clog2(STAGES);

  logic                id_valid;
  logic [REG_BITS-1:0] id_rs;
  logic                id_rs_used;
  logic [REG_BITS-1:0] id_rt;
  logic                id_rt_used;
  logic                id_wr_en;
  logic [REG_BITS-1:0] id_rd;
  logic                id_is_load;
  logic                flush;
  logic                stall_ext;
  logic                stall_id;
  logic [FWD_W-1:0]    fwd_a;
  logic [FWD_W-1:0]    fwd_b;
  logic [STAGES-1:0]   slot_valid;
  logic [CNT_W-1:0]    stall_cycles;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_rd, id_is_load, flush, stall_ext,
    input  stall_id, fwd_a, fwd_b, slot_valid, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_rd, id_is_load, flush, stall_ext,
    output stall_id, fwd_a, fwd_b, slot_valid, stall_cycles
  );

endinterface

// File: rtl/hazard_forward_ctrl_match.sv
// Combinational producer search for one source register.
//   i_src, i_src_used : source register number and whether it is read.
//   i_slots           : slots 0..STAGES-2 (they become 1..STAGES-1 next cycle).
//   o_hit             : some slot produces i_src.
//   o_dist            : match distance j = index+1 of the youngest producer.
//   o_is_load         : that producer is a load.
module hazard_match
  import pipe_ctrl_pkg::*;
#(
  parameter  int REG_BITS = 5,
  parameter  int STAGES   = 3,
  localparam int FWD_W    = clog2(STAGES)
) (
  input  logic [REG_BITS-1:0] i_src,
  input  logic                i_src_used,
  input  slot_t [STAGES-2:0]  i_slots,
  output logic                o_hit,
  output logic [FWD_W-1:0]    o_dist,
  output logic                o_is_load
);

  logic [REG_BITS_MAX-1:0] w_src_ext;

  assign w_src_ext = REG_BITS_MAX'(i_src);

  // Scan oldest to youngest so the lowest index overwrites and wins.
  always_comb begin
    o_hit     = 1'b0;
    o_dist    = FWD_W'(FWD_RF);
    o_is_load = 1'b0;
    if (i_src_used && (i_src != '0)) begin
      for (int i = STAGES - 2; i >= 0; i--) begin
        if (i_slots[i].valid && i_slots[i].wr_en && (i_slots[i].rd == w_src_ext)) begin
          o_hit     = 1'b1;
          o_dist    = FWD_W'(i + 1);
          o_is_load = i_slots[i].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks STAGES post-decode slots (slot 0 = EX, slot STAGES-1 = WB), issues
// registered forward selects for the instruction entering EX, raises load-use
// stalls for any load-ready depth, and counts stall cycles (saturating).
//   clk, reset : clock, asynchronous active-high reset.
//   bus        : hazard_forward_ctrl_if slave (ID instruction, flush, stall_ext in;
//                stall_id, fwd_a, fwd_b, slot_valid, stall_cycles out).
module hazard_forward_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter  int REG_BITS         = 5,
  parameter  int STAGES           = 3,
  parameter  int LOAD_READY_STAGE = 2,
  parameter  int CNT_W            = 16,
  localparam int FWD_W            = clog2(STAGES)
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_forward_ctrl_if.slave bus
);

  generate
    if (!params_legal(REG_BITS, STAGES, LOAD_READY_STAGE, CNT_W)) begin : g_bad_params
      $error("hazard_forward_ctrl: illegal parameter combination");
    end
  endgenerate

  localparam logic [FWD_W-1:0] LRS_SEL = FWD_W'(LOAD_READY_STAGE);

  slot_t [STAGES-1:0] r_slots;
  logic  [FWD_W-1:0]  r_fwd_a_p0;
  logic  [FWD_W-1:0]  r_fwd_b_p0;
  logic  [CNT_W-1:0]  r_stall_cnt;

  logic               w_hit_a, w_hit_b;
  logic               w_load_a, w_load_b;
  logic [FWD_W-1:0]   w_dist_a, w_dist_b;
  logic               w_stall_id;
  logic               w_issue;
  slot_t              w_slot_in;
  logic [STAGES-1:0]  w_slot_valid;

  hazard_match #(.REG_BITS(REG_BITS), .STAGES(STAGES)) u_match_rs (
    .i_src      (bus.id_rs),
    .i_src_used (bus.id_rs_used),
    .i_slots    (r_slots[STAGES-2:0]),
    .o_hit      (w_hit_a),
    .o_dist     (w_dist_a),
    .o_is_load  (w_load_a)
  );

  hazard_match #(.REG_BITS(REG_BITS), .STAGES(STAGES)) u_match_rt (
    .i_src      (bus.id_rt),
    .i_src_used (bus.id_rt_used),
    .i_slots    (r_slots[STAGES-2:0]),
    .o_hit      (w_hit_b),
    .o_dist     (w_dist_b),
    .o_is_load  (w_load_b)
  );

  // A load whose winning match is still short of the load-ready slot cannot be
  // forwarded yet; flush overrides so the PC is free to redirect.
  assign w_stall_id = bus.id_valid && !bus.flush &&
                      ((w_hit_a && w_load_a && (w_dist_a < LRS_SEL)) ||
                       (w_hit_b && w_load_b && (w_dist_b < LRS_SEL)));

  assign w_issue = bus.id_valid && !w_stall_id && !bus.flush;

  // Register 0 is never a producer: mask its write enable at slot entry.
  always_comb begin
    w_slot_in         = '0;
    w_slot_in.valid   = 1'b1;
    w_slot_in.wr_en   = bus.id_wr_en && (bus.id_rd != '0);
    w_slot_in.rd      = REG_BITS_MAX'(bus.id_rd);
    w_slot_in.is_load = bus.id_is_load;
  end

  // ID -> EX boundary: slot shift, forward selects, stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slots     <= '0;
      r_fwd_a_p0  <= FWD_W'(FWD_RF);
      r_fwd_b_p0  <= FWD_W'(FWD_RF);
      r_stall_cnt <= '0;
    end else if (!bus.stall_ext) begin
      for (int i = 1; i < STAGES; i++) begin
        r_slots[i] <= r_slots[i-1];
      end
      if (w_issue) begin
        r_slots[0] <= w_slot_in;
        r_fwd_a_p0 <= w_dist_a;
        r_fwd_b_p0 <= w_dist_b;
      end else begin
        r_slots[0] <= '0;
        r_fwd_a_p0 <= FWD_W'(FWD_RF);
        r_fwd_b_p0 <= FWD_W'(FWD_RF);
      end
      if (w_stall_id && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_slot_valid = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_slot_valid[i] = r_slots[i].valid;
    end
  end

  assign bus.stall_id     = w_stall_id;
  assign bus.fwd_a        = r_fwd_a_p0;
  assign bus.fwd_b        = r_fwd_b_p0;
  assign bus.slot_valid   = w_slot_valid;
  assign bus.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl. Two instances: A (STAGES=3, L=2,
// CNT_W=16) and B (STAGES=4, L=3, CNT_W=2 so saturation is reachable).
// Stimulus is applied 1 time unit after each rising edge and the expected
// outputs for that cycle are queued; the monitor pops and compares on the
// falling edge.
module tb_hazard_forward_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.REG_BITS(5), .STAGES(3), .CNT_W(16)) ifa ();
  hazard_forward_ctrl_if #(.REG_BITS(5), .STAGES(4), .CNT_W(2))  ifb ();

  hazard_forward_ctrl #(.REG_BITS(5), .STAGES(3), .LOAD_READY_STAGE(2), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  hazard_forward_ctrl #(.REG_BITS(5), .STAGES(4), .LOAD_READY_STAGE(3), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  typedef struct {
    int    dut;
    int    stall;
    int    fa;
    int    fb;
    int    sv;
    int    cnt;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic drive(input int dut, input bit v, input int rs, input bit rsu,
                       input int rt, input bit rtu, input bit wr, input int rd,
                       input bit ld, input bit fl, input bit sx);
    ifa.id_valid = 1'b0; ifa.id_rs = '0; ifa.id_rs_used = 1'b0; ifa.id_rt = '0;
    ifa.id_rt_used = 1'b0; ifa.id_wr_en = 1'b0; ifa.id_rd = '0; ifa.id_is_load = 1'b0;
    ifa.flush = 1'b0; ifa.stall_ext = 1'b0;
    ifb.id_valid = 1'b0; ifb.id_rs = '0; ifb.id_rs_used = 1'b0; ifb.id_rt = '0;
    ifb.id_rt_used = 1'b0; ifb.id_wr_en = 1'b0; ifb.id_rd = '0; ifb.id_is_load = 1'b0;
    ifb.flush = 1'b0; ifb.stall_ext = 1'b0;
    if (dut == 0) begin
      ifa.id_valid = v; ifa.id_rs = 5'(rs); ifa.id_rs_used = rsu; ifa.id_rt = 5'(rt);
      ifa.id_rt_used = rtu; ifa.id_wr_en = wr; ifa.id_rd = 5'(rd); ifa.id_is_load = ld;
      ifa.flush = fl; ifa.stall_ext = sx;
    end else begin
      ifb.id_valid = v; ifb.id_rs = 5'(rs); ifb.id_rs_used = rsu; ifb.id_rt = 5'(rt);
      ifb.id_rt_used = rtu; ifb.id_wr_en = wr; ifb.id_rd = 5'(rd); ifb.id_is_load = ld;
      ifb.flush = fl; ifb.stall_ext = sx;
    end
  endtask

  task automatic push(input string tag, input int dut, input int es, input int efa,
                      input int efb, input int esv, input int ecnt);
    exp_t e;
    e.tag = tag; e.dut = dut; e.stall = es; e.fa = efa; e.fb = efb; e.sv = esv; e.cnt = ecnt;
    sb.push_back(e);
  endtask

  // One ID cycle: inputs v,rs,rsu,rt,rtu,wr,rd,ld,flush,stall_ext then the
  // expected stall_id (this cycle) and registered outputs from the previous issue.
  task automatic step(input string tag, input int dut,
                      input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                      input bit wr, input int rd, input bit ld, input bit fl, input bit sx,
                      input int es, input int efa, input int efb, input int esv, input int ecnt);
    @(posedge clk);
    #1;
    drive(dut, v, rs, rsu, rt, rtu, wr, rd, ld, fl, sx);
    push(tag, dut, es, efa, efb, esv, ecnt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.dut == 0) begin
          chk({e.tag, " stall_id"},     int'(ifa.stall_id),     e.stall);
          chk({e.tag, " fwd_a"},        int'(ifa.fwd_a),        e.fa);
          chk({e.tag, " fwd_b"},        int'(ifa.fwd_b),        e.fb);
          chk({e.tag, " slot_valid"},   int'(ifa.slot_valid),   e.sv);
          chk({e.tag, " stall_cycles"}, int'(ifa.stall_cycles), e.cnt);
        end else begin
          chk({e.tag, " stall_id"},     int'(ifb.stall_id),     e.stall);
          chk({e.tag, " fwd_a"},        int'(ifb.fwd_a),        e.fa);
          chk({e.tag, " fwd_b"},        int'(ifb.fwd_b),        e.fb);
          chk({e.tag, " slot_valid"},   int'(ifb.slot_valid),   e.sv);
          chk({e.tag, " stall_cycles"}, int'(ifb.stall_cycles), e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;

    // ---- Instance A: STAGES=3, LOAD_READY_STAGE=2 ----
    //         tag  d  v rs u rt u wr rd ld fl sx | st fa fb sv     cnt
    step("A1",  0, 1, 1,1, 2,1, 1, 3, 0, 0,0,  0, 0, 0, 'b000, 0);
    step("A2",  0, 1, 6,1, 7,1, 1, 3, 0, 0,0,  0, 0, 0, 'b001, 0);
    step("A3",  0, 1, 3,1, 4,1, 1, 5, 0, 0,0,  0, 0, 0, 'b011, 0);  // two $3 writers in flight
    step("A4",  0, 1, 9,1, 3,1, 1,10, 0, 0,0,  0, 1, 0, 'b111, 0);  // youngest wins -> fwd_a=1
    step("A5",  0, 1, 0,1, 0,0, 1, 4, 1, 0,0,  0, 0, 2, 'b111, 0);  // rt=$3 at distance 2
    step("A6",  0, 1, 4,1, 2,1, 1, 6, 0, 0,0,  1, 0, 0, 'b111, 0);  // load-use, distance 1
    step("A7",  0, 1, 4,1, 2,1, 1, 6, 0, 0,0,  0, 0, 0, 'b110, 1);  // bubble in slot 0
    step("A8",  0, 1, 1,1, 2,1, 1, 0, 0, 0,0,  0, 2, 0, 'b101, 1);  // producer rd=0
    step("A9",  0, 1, 0,1, 6,0, 1, 7, 0, 0,0,  0, 0, 0, 'b011, 1);  // rs=0, rt unused
    step("A10", 0, 1, 1,1, 0,0, 1,12, 1, 0,0,  0, 0, 0, 'b111, 1);
    step("A11", 0, 1,12,1, 0,0, 1,13, 0, 1,0,  0, 0, 0, 'b111, 1);  // load-use under flush
    step("A12", 0, 0, 0,0, 0,0, 0, 0, 0, 0,0,  0, 0, 0, 'b110, 1);
    step("A13", 0, 1, 1,1, 2,1, 1, 3, 0, 0,0,  0, 0, 0, 'b100, 1);
    step("A14", 0, 1, 3,1, 0,0, 1, 4, 1, 0,0,  0, 0, 0, 'b001, 1);
    step("A15", 0, 1, 4,1, 4,1, 1, 5, 0, 0,1,  1, 1, 0, 'b011, 1);  // freeze 3 cycles
    step("A16", 0, 1, 4,1, 4,1, 1, 5, 0, 0,1,  1, 1, 0, 'b011, 1);
    step("A17", 0, 1, 4,1, 4,1, 1, 5, 0, 0,1,  1, 1, 0, 'b011, 1);
    step("A18", 0, 1, 4,1, 4,1, 1, 5, 0, 0,0,  1, 1, 0, 'b011, 1);
    step("A19", 0, 1, 4,1, 4,1, 1, 5, 0, 0,0,  0, 0, 0, 'b110, 2);
    step("A20", 0, 0, 0,0, 0,0, 0, 0, 0, 0,0,  0, 2, 2, 'b101, 2);
    step("A21", 0, 1, 1,1, 2,1, 1, 3, 0, 0,0,  0, 0, 0, 'b010, 2);
    step("A22", 0, 1, 3,1, 5,1, 1, 7, 0, 0,0,  0, 0, 0, 'b101, 2);
    step("A23", 0, 1, 7,1, 0,0, 1, 8, 1, 0,0,  0, 1, 0, 'b011, 2);

    // Mid-stream asynchronous reset with a load-use candidate in ID.
    @(posedge clk);
    #1;
    drive(0, 1, 8, 1, 0, 0, 1, 9, 0, 0, 0);
    #1 reset = 1'b1;
    push("A24rst", 0, 0, 0, 0, 'b000, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("A25", 0, 0, 0,0, 0,0, 0, 0, 0, 0,0,  0, 0, 0, 'b000, 0);

    // ---- Instance B: STAGES=4, LOAD_READY_STAGE=3, CNT_W=2 ----
    step("B1",  1, 1, 1,1, 2,1, 1, 3, 0, 0,0,  0, 0, 0, 'b0000, 0);
    step("B2",  1, 1, 1,1, 2,1, 1, 9, 0, 0,0,  0, 0, 0, 'b0001, 0);
    step("B3",  1, 1, 1,1, 2,1, 1,10, 0, 0,0,  0, 0, 0, 'b0011, 0);
    step("B4",  1, 1, 1,1, 3,1, 1,11, 0, 0,0,  0, 0, 0, 'b0111, 0);  // rt=$3 at distance 3
    step("B5",  1, 1, 1,1, 0,0, 1, 4, 1, 0,0,  0, 0, 3, 'b1111, 0);
    step("B6",  1, 1, 4,1, 2,1, 1, 6, 0, 0,0,  1, 0, 0, 'b1111, 0);  // two-cycle load-use
    step("B7",  1, 1, 4,1, 2,1, 1, 6, 0, 0,0,  1, 0, 0, 'b1110, 1);
    step("B8",  1, 1, 4,1, 2,1, 1, 6, 0, 0,0,  0, 0, 0, 'b1100, 2);
    step("B9",  1, 1, 1,1, 0,0, 1, 5, 1, 0,0,  0, 3, 0, 'b1001, 2);
    step("B10", 1, 1, 2,1, 5,1, 1, 7, 0, 0,0,  1, 0, 0, 'b0011, 2);
    step("B11", 1, 1, 2,1, 5,1, 1, 7, 0, 0,0,  1, 0, 0, 'b0110, 3);
    step("B12", 1, 1, 2,1, 5,1, 1, 7, 0, 0,0,  0, 0, 0, 'b1100, 3);  // counter saturated
    step("B13", 1, 0, 0,0, 0,0, 0, 0, 0, 0,0,  0, 0, 3, 'b1001, 3);

    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
